// File: rtl/axis_pair_packer_if.sv
// Stream bundle around the even/odd pair packer: sample input side and pair output side.
// The master modport is the packer's view and the slave modport is the surrounding environment's view.
interface axis_pair_packer_if #(
    parameter int unsigned DataWidth = 16
);
    logic [DataWidth-1:0]   s_data_i;
    logic                   s_valid_i;
    logic                   s_last_i;
    logic                   s_ready_o;

    logic [2*DataWidth-1:0] m_data_o;
    logic                   m_valid_o;
    logic                   m_last_o;
    logic                   m_pad_o;
    logic                   m_ready_i;

    modport master (
        input  s_data_i,
        input  s_valid_i,
        input  s_last_i,
        output s_ready_o,
        output m_data_o,
        output m_valid_o,
        output m_last_o,
        output m_pad_o,
        input  m_ready_i
    );

    modport slave (
        output s_data_i,
        output s_valid_i,
        output s_last_i,
        input  s_ready_o,
        input  m_data_o,
        input  m_valid_o,
        input  m_last_o,
        input  m_pad_o,
        output m_ready_i
    );
endinterface

// File: rtl/axis_pair_packer.sv
// Packs a line of samples into {odd, even} pairs for the lifting DWT, with whole-sample
// symmetric extension on odd-length lines. Output register is a single AXI-stream stage.
module axis_pair_packer #(
    parameter int unsigned DataWidth = 16
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    axis_pair_packer_if.master     bus
);
    localparam logic [0:0] EMPTY     = 1'b0;
    localparam logic [0:0] HAVE_EVEN = 1'b1;

    logic [0:0]             state_q;
    logic [DataWidth-1:0]   even_q;
    logic [DataWidth-1:0]   prev_odd_q;
    logic                   first_q;

    logic [2*DataWidth-1:0] m_data_q;
    logic                   m_valid_q;
    logic                   m_last_q;
    logic                   m_pad_q;

    logic                   out_free;
    logic                   accept;
    logic                   load;
    logic [DataWidth-1:0]   ext_odd;

    // Ready depends only on the output stage, never on the input handshake.
    always_comb begin
        out_free = !m_valid_q || bus.m_ready_i;
        accept   = bus.s_valid_i && out_free;
        load     = accept && ((state_q == HAVE_EVEN) || bus.s_last_i);
        ext_odd  = first_q ? bus.s_data_i : prev_odd_q;
    end

    assign bus.s_ready_o = out_free;
    assign bus.m_data_o  = m_data_q;
    assign bus.m_valid_o = m_valid_q;
    assign bus.m_last_o  = m_last_q;
    assign bus.m_pad_o   = m_pad_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= EMPTY;
            even_q     <= '0;
            prev_odd_q <= '0;
            first_q    <= 1'b1;
            m_data_q   <= '0;
            m_valid_q  <= 1'b0;
            m_last_q   <= 1'b0;
            m_pad_q    <= 1'b0;
        end else begin
            if (!load && bus.m_ready_i) begin
                m_valid_q <= 1'b0;
            end
            if (accept) begin
                case (state_q)
                    EMPTY: begin
                        if (!bus.s_last_i) begin
                            even_q  <= bus.s_data_i;
                            state_q <= HAVE_EVEN;
                        end else begin
                            // Odd-length line: mirror x[N-2] (or x[0] for N=1) into the odd half.
                            m_data_q  <= {ext_odd, bus.s_data_i};
                            m_last_q  <= 1'b1;
                            m_pad_q   <= 1'b1;
                            m_valid_q <= 1'b1;
                            first_q   <= 1'b1;
                        end
                    end
                    HAVE_EVEN: begin
                        m_data_q   <= {bus.s_data_i, even_q};
                        m_last_q   <= bus.s_last_i;
                        m_pad_q    <= 1'b0;
                        m_valid_q  <= 1'b1;
                        prev_odd_q <= bus.s_data_i;
                        first_q    <= bus.s_last_i;
                        state_q    <= EMPTY;
                    end
                    default: state_q <= EMPTY;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_axis_pair_packer.sv
// Directed and randomised checks of the pair packer against hand-computed pairs and a line model.
module tb_axis_pair_packer;
    typedef struct {
        logic [31:0] data;
        logic        last;
        logic        pad;
    } pair_t;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_err;
    int   rdy_mode;
    pair_t exp_q[$];

    axis_pair_packer_if #(.DataWidth(16)) if16 ();
    axis_pair_packer_if #(.DataWidth(8))  if8 ();

    axis_pair_packer #(.DataWidth(16)) u_dut16 (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (if16.master)
    );

    axis_pair_packer #(.DataWidth(8)) u_dut8 (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (if8.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic void expect_pair(input logic [15:0] odd, input logic [15:0] even,
                                        input logic last, input logic pad);
        pair_t p;
        p.data = {odd, even};
        p.last = last;
        p.pad  = pad;
        exp_q.push_back(p);
    endfunction

    // Downstream ready: 0 = held low, 1 = held high, 2 = random each cycle.
    initial begin
        if16.m_ready_i = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0:       if16.m_ready_i = 1'b0;
                1:       if16.m_ready_i = 1'b1;
                default: if16.m_ready_i = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Output monitor: pops the expected queue on every handshake and checks stall stability.
    logic        stalled;
    logic [31:0] hold_data;
    logic        hold_last;
    logic        hold_pad;
    initial stalled = 1'b0;

    always @(negedge clk) begin
        if (!rst_n) begin
            stalled <= 1'b0;
        end else begin
            if (stalled) begin
                check("hold_valid", 64'(if16.m_valid_o), 64'd1);
                check("hold_data", 64'(if16.m_data_o), 64'(hold_data));
                check("hold_last", 64'(if16.m_last_o), 64'(hold_last));
                check("hold_pad", 64'(if16.m_pad_o), 64'(hold_pad));
            end
            if (if16.m_valid_o && if16.m_ready_i) begin
                if (exp_q.size() == 0) begin
                    check("extra_pair", 64'(if16.m_data_o), 64'hDEAD_BEEF_DEAD);
                end else begin
                    check("pair_data", 64'(if16.m_data_o), 64'(exp_q[0].data));
                    check("pair_last", 64'(if16.m_last_o), 64'(exp_q[0].last));
                    check("pair_pad", 64'(if16.m_pad_o), 64'(exp_q[0].pad));
                    void'(exp_q.pop_front());
                end
            end
            stalled   <= if16.m_valid_o && !if16.m_ready_i;
            hold_data <= if16.m_data_o;
            hold_last <= if16.m_last_o;
            hold_pad  <= if16.m_pad_o;
        end
    end

    // Called at posedge+1; returns at posedge+1 right after the sample was accepted.
    task automatic send_sample(input logic [15:0] d, input logic last, output int stalls);
        bit ok;
        stalls = 0;
        if16.s_valid_i = 1'b1;
        if16.s_data_i  = d;
        if16.s_last_i  = last;
        ok = 1'b0;
        while (!ok && stalls < 1000) begin
            @(negedge clk);
            if (if16.s_ready_o) ok = 1'b1;
            else begin
                stalls++;
                @(posedge clk);
                #1;
            end
        end
        if (!ok) check("accept_timeout", 64'(stalls), 64'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic wait_drain();
        int unsigned i;
        i = 0;
        while (exp_q.size() != 0 && i < 5000) begin
            @(negedge clk);
            i++;
        end
        check("drain", 64'(exp_q.size()), 64'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int st;
        int tot;
        logic [15:0] x[8];
        int n;
        n_cmp    = 0;
        n_err    = 0;
        rdy_mode = 1;
        rst_n    = 1'b0;
        if16.s_valid_i = 1'b0;
        if16.s_data_i  = '0;
        if16.s_last_i  = 1'b0;
        if8.s_valid_i  = 1'b0;
        if8.s_data_i   = '0;
        if8.s_last_i   = 1'b0;
        if8.m_ready_i  = 1'b1;

        repeat (2) @(negedge clk);
        check("rst_valid", 64'(if16.m_valid_o), 64'd0);
        check("rst_last", 64'(if16.m_last_o), 64'd0);
        check("rst_pad", 64'(if16.m_pad_o), 64'd0);
        check("rst_data", 64'(if16.m_data_o), 64'd0);
        check("rst_ready", 64'(if16.s_ready_o), 64'd1);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Even-length line, free-flowing output.
        expect_pair(16'd11, 16'd10, 1'b0, 1'b0);
        expect_pair(16'd13, 16'd12, 1'b1, 1'b0);
        tot = 0;
        send_sample(16'd10, 1'b0, st); tot += st;
        send_sample(16'd11, 1'b0, st); tot += st;
        send_sample(16'd12, 1'b0, st); tot += st;
        send_sample(16'd13, 1'b1, st); tot += st;
        if16.s_valid_i = 1'b0;
        check("t1_no_stall", 64'(tot), 64'd0);
        wait_drain();

        // Odd-length line: extension copies x[1].
        expect_pair(16'd6, 16'd5, 1'b0, 1'b0);
        expect_pair(16'd6, 16'd7, 1'b1, 1'b1);
        send_sample(16'd5, 1'b0, st);
        send_sample(16'd6, 1'b0, st);
        send_sample(16'd7, 1'b1, st);
        if16.s_valid_i = 1'b0;
        wait_drain();

        // Single-sample line, then a fresh line proving first_q restored.
        expect_pair(16'd42, 16'd42, 1'b1, 1'b1);
        expect_pair(16'd2, 16'd1, 1'b1, 1'b0);
        send_sample(16'd42, 1'b1, st);
        send_sample(16'd1, 1'b0, st);
        send_sample(16'd2, 1'b1, st);
        if16.s_valid_i = 1'b0;
        wait_drain();

        // Backpressure with a sample waiting at the input.
        rdy_mode = 0;
        if16.m_ready_i = 1'b0;
        expect_pair(16'd21, 16'd20, 1'b0, 1'b0);
        expect_pair(16'd23, 16'd22, 1'b1, 1'b0);
        send_sample(16'd20, 1'b0, st);
        send_sample(16'd21, 1'b0, st);
        if16.s_valid_i = 1'b1;
        if16.s_data_i  = 16'd22;
        if16.s_last_i  = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_valid", 64'(if16.m_valid_o), 64'd1);
            check("bp_data", 64'(if16.m_data_o), 64'h0015_0014);
            check("bp_sready", 64'(if16.s_ready_o), 64'd0);
        end
        rdy_mode = 1;
        if16.m_ready_i = 1'b1;
        @(posedge clk);
        #1;
        send_sample(16'd23, 1'b1, st);
        if16.s_valid_i = 1'b0;
        wait_drain();

        // Random valid/ready against the line model.
        rdy_mode = 2;
        for (int ln = 0; ln < 1000; ln++) begin
            n = $urandom_range(1, 7);
            for (int k = 0; k < n; k++) x[k] = 16'($urandom);
            for (int k = 0; k + 1 < n; k += 2)
                expect_pair(x[k+1], x[k], 1'(k + 2 == n), 1'b0);
            if (n % 2 == 1)
                expect_pair((n == 1) ? x[0] : x[n-2], x[n-1], 1'b1, 1'b1);
            for (int k = 0; k < n; k++) begin
                if ($urandom_range(0, 3) == 0) begin
                    if16.s_valid_i = 1'b0;
                    @(posedge clk);
                    #1;
                end
                send_sample(x[k], 1'(k == n - 1), st);
            end
        end
        if16.s_valid_i = 1'b0;
        rdy_mode = 1;
        wait_drain();

        // Asynchronous reset with an even sample held.
        send_sample(16'd7, 1'b0, st);
        if16.s_valid_i = 1'b0;
        #2 rst_n = 1'b0;
        #1 check("rst_he_valid", 64'(if16.m_valid_o), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        // Asynchronous reset with a stalled pair in the output register.
        rdy_mode = 0;
        if16.m_ready_i = 1'b0;
        @(posedge clk);
        #1;
        send_sample(16'd8, 1'b0, st);
        send_sample(16'd9, 1'b1, st);
        if16.s_valid_i = 1'b0;
        #2 check("pre_rst_valid", 64'(if16.m_valid_o), 64'd1);
        rst_n = 1'b0;
        #1;
        check("rst_mid_valid", 64'(if16.m_valid_o), 64'd0);
        check("rst_mid_last", 64'(if16.m_last_o), 64'd0);
        check("rst_mid_data", 64'(if16.m_data_o), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        rdy_mode = 1;
        if16.m_ready_i = 1'b1;
        @(posedge clk);
        #1;
        expect_pair(16'd4, 16'd3, 1'b1, 1'b0);
        send_sample(16'd3, 1'b0, st);
        send_sample(16'd4, 1'b1, st);
        if16.s_valid_i = 1'b0;
        wait_drain();

        // 8-bit instance, back-to-back lines.
        if8.s_valid_i = 1'b1;
        if8.s_data_i  = 8'hFF;
        if8.s_last_i  = 1'b0;
        @(posedge clk); #1;
        if8.s_data_i  = 8'h00;
        if8.s_last_i  = 1'b1;
        @(posedge clk); #1;
        if8.s_data_i  = 8'h12;
        if8.s_last_i  = 1'b0;
        @(negedge clk);
        check("w8_data0", 64'(if8.m_data_o), 64'h00FF);
        check("w8_valid0", 64'(if8.m_valid_o), 64'd1);
        check("w8_last0", 64'(if8.m_last_o), 64'd1);
        check("w8_sready", 64'(if8.s_ready_o), 64'd1);
        @(posedge clk); #1;
        if8.s_data_i  = 8'h34;
        if8.s_last_i  = 1'b1;
        @(negedge clk);
        check("w8_sready2", 64'(if8.s_ready_o), 64'd1);
        @(posedge clk); #1;
        if8.s_valid_i = 1'b0;
        @(negedge clk);
        check("w8_data1", 64'(if8.m_data_o), 64'h3412);
        check("w8_valid1", 64'(if8.m_valid_o), 64'd1);
        check("w8_pad1", 64'(if8.m_pad_o), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
